// File: rtl/rotate_sdram_sched_if.sv
// rtl/rotate_sdram_sched_if.sv - video write/read streams and SDRAM word port bundle
interface rotate_sdram_sched_if #(
  parameter int ADDR_WIDTH = 21
);
  logic [1:0]            rotation;
  logic                  vidin_req;
  logic                  vidin_frame;
  logic [9:0]            vidin_row;
  logic [9:0]            vidin_col;
  logic [15:0]           vidin_d;
  logic                  vidin_ack;
  logic                  vidout_req;
  logic                  vidout_frame;
  logic [9:0]            vidout_row;
  logic [9:0]            vidout_col;
  logic [15:0]           vidout_d;
  logic                  vidout_ack;
  logic                  mem_req;
  logic                  mem_we;
  logic                  mem_last;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;
  logic                  mem_ack;

  modport master (
    input  rotation, vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    input  vidout_req, vidout_frame, vidout_row, vidout_col, mem_rdata, mem_ack,
    output vidin_ack, vidout_d, vidout_ack, mem_req, mem_we, mem_last, mem_addr, mem_wdata
  );

  modport slave (
    output rotation, vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    output vidout_req, vidout_frame, vidout_row, vidout_col, mem_rdata, mem_ack,
    input  vidin_ack, vidout_d, vidout_ack, mem_req, mem_we, mem_last, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rotate_sdram_sched.sv
// rtl/rotate_sdram_sched.sv - fair scheduler of cornerturned write and linear read bursts onto one SDRAM word port
module rotate_sdram_sched #(
  parameter int ADDR_WIDTH = 21,
  parameter int WRITE_GAP  = 2,
  parameter int READ_BURST = 8
) (
  input logic                  clk_sys,
  input logic                  reset,
  rotate_sdram_sched_if.master bus
);

  localparam int KW = ($clog2(READ_BURST) > 4) ? $clog2(READ_BURST) : 4;
  localparam int GW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WGAP, ST_READ} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q;
  logic [GW-1:0]   gap_q;
  logic            last_was_write_q;
  logic            dir_q;
  logic            frame_q;
  logic [9:0]      row_q;
  logic [9:0]      col_q;
  logic            vidout_ack_q;
  logic [15:0]     vidout_d_q;
  logic            grant_write, grant_read;
  logic            wr_last, rd_last;
  logic [3:0]      lo;
  logic [9:0]      rd_minor;
  logic [20:0]     addr21;
  logic            mem_req_c, mem_we_c, mem_last_c, vidin_ack_c, rd_ack_c;
  logic            unused_bits;

  assign unused_bits = ^{bus.rotation[1], bus.vidin_col[3:0]};

  // With both streams waiting, the one not served last wins.
  assign grant_write = bus.vidin_req && (!bus.vidout_req || !last_was_write_q);
  assign grant_read  = bus.vidout_req && !grant_write;

  assign wr_last  = (k_q == KW'(15));
  assign rd_last  = (k_q == KW'(READ_BURST - 1)) || !bus.vidout_req;
  assign lo       = dir_q ? k_q[3:0] : 4'd15 - k_q[3:0];
  assign rd_minor = col_q + 10'(k_q);
  // Writes are cornerturned: the source column becomes the major index.
  assign addr21   = (state_q == ST_READ) ? {frame_q, row_q, rd_minor}
                                         : {frame_q, col_q[9:4], lo, row_q};

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_last_c  = 1'b0;
    vidin_ack_c = 1'b0;
    rd_ack_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_write)     state_d = ST_WRITE;
        else if (grant_read) state_d = ST_READ;
      end
      ST_WRITE: begin
        if (bus.mem_ack) begin
          if (wr_last)             state_d = ST_IDLE;
          else if (WRITE_GAP == 0) state_d = bus.vidin_req ? ST_WRITE : ST_IDLE;
          else                     state_d = ST_WGAP;
        end
      end
      ST_WGAP: begin
        if (gap_q == GW'(WRITE_GAP - 1)) state_d = bus.vidin_req ? ST_WRITE : ST_IDLE;
      end
      ST_READ: begin
        if (bus.mem_ack && rd_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!reset) begin
      if (state_q == ST_WRITE) begin
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_last_c  = wr_last;
        vidin_ack_c = bus.mem_ack;
      end else if (state_q == ST_READ) begin
        mem_req_c  = 1'b1;
        mem_last_c = rd_last;
        rd_ack_c   = bus.mem_ack;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      k_q              <= '0;
      gap_q            <= '0;
      last_was_write_q <= 1'b0;
      dir_q            <= 1'b0;
      frame_q          <= 1'b0;
      row_q            <= '0;
      col_q            <= '0;
      vidout_ack_q     <= 1'b0;
      vidout_d_q       <= '0;
    end else begin
      vidout_ack_q <= rd_ack_c;
      if (rd_ack_c) vidout_d_q <= bus.mem_rdata;
      if (state_q == ST_IDLE && grant_write) begin
        last_was_write_q <= 1'b1;
        frame_q          <= bus.vidin_frame;
        row_q            <= bus.vidin_row;
        col_q            <= {bus.vidin_col[9:4], 4'd0};
        dir_q            <= bus.rotation[0];
        k_q              <= '0;
      end else if (state_q == ST_IDLE && grant_read) begin
        last_was_write_q <= 1'b0;
        frame_q          <= bus.vidout_frame;
        row_q            <= bus.vidout_row;
        col_q            <= bus.vidout_col;
        k_q              <= '0;
      end
      if ((state_q == ST_WRITE || state_q == ST_READ) && bus.mem_ack) k_q <= k_q + 1'b1;
      if (state_q == ST_WGAP) gap_q <= gap_q + 1'b1;
      else                    gap_q <= '0;
    end
  end

  assign bus.mem_req    = mem_req_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_last   = mem_last_c;
  assign bus.mem_addr   = ADDR_WIDTH'(addr21);
  assign bus.mem_wdata  = bus.vidin_d;
  assign bus.vidin_ack  = vidin_ack_c;
  assign bus.vidout_ack = vidout_ack_q;
  assign bus.vidout_d   = vidout_d_q;

endmodule

// File: tb/tb_rotate_sdram_sched.sv
// tb/tb_rotate_sdram_sched.sv - self-checking bench for rotate_sdram_sched
module tb_rotate_sdram_sched;
  localparam int ADDR_WIDTH = 21;
  localparam int WRITE_GAP  = 2;
  localparam int READ_BURST = 8;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  int   lat_max = 0;
  bit   lat_fixed = 1'b0;
  int   cur_lat = 0;
  int   wait_cnt = 0;

  typedef struct {
    logic        we;
    logic        last;
    logic [20:0] addr;
    logic [15:0] wdata;
    logic [15:0] vin_d;
    int          cyc;
  } word_t;

  typedef struct {
    bit          is_write;
    logic [1:0]  rot;
    bit          frame;
    logic [9:0]  row;
    logic [9:0]  col;
    int          n_words;
    logic [20:0] first_addr;
    logic [20:0] last_addr;
  } vec_t;

  word_t       words[$];
  int          vin_cyc[$];
  int          vout_cyc[$];
  logic [15:0] vout_d[$];

  rotate_sdram_sched_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  rotate_sdram_sched #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WRITE_GAP (WRITE_GAP),
    .READ_BURST(READ_BURST)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [15:0] rdata_of(input logic [20:0] a);
    return a[15:0] ^ 16'h5a3c ^ {11'd0, a[20:16]};
  endfunction

  function automatic logic [20:0] model_addr(input bit is_write, input bit rot0, input int frame,
                                             input int row, input int col, input int i);
    int v;
    if (is_write) v = frame * (1 << 20) + ((col / 16) * 16 + (rot0 ? i : 15 - i)) * 1024 + row;
    else          v = frame * (1 << 20) + row * 1024 + (col + i) % 1024;
    return v[20:0];
  endfunction

  always @(negedge clk_sys) begin
    if (bus.mem_req && bus.mem_ack)
      words.push_back('{bus.mem_we, bus.mem_last, bus.mem_addr, bus.mem_wdata, bus.vidin_d, cyc});
    if (bus.vidin_ack) vin_cyc.push_back(cyc);
    if (bus.vidout_ack) begin
      vout_cyc.push_back(cyc);
      vout_d.push_back(bus.vidout_d);
    end
  end

  initial begin : responder
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'd0;
    forever begin
      @(posedge clk_sys);
      #2;
      if (bus.mem_req && wait_cnt >= cur_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata_of(bus.mem_addr);
        wait_cnt      = 0;
        cur_lat       = lat_fixed ? lat_max : int'($urandom_range(lat_max, 0));
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt    = bus.mem_req ? wait_cnt + 1 : 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    words.delete();
    vin_cyc.delete();
    vout_cyc.delete();
    vout_d.delete();
    wait_cnt = 0;
    cur_lat  = lat_fixed ? lat_max : 0;
  endtask

  task automatic quiesce();
    bus.vidin_req  = 1'b0;
    bus.vidout_req = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic scramble_fields();
    bus.rotation     = 2'($urandom);
    bus.vidin_frame  = 1'($urandom);
    bus.vidin_row    = 10'($urandom);
    bus.vidin_col    = 10'($urandom);
    bus.vidout_frame = 1'($urandom);
    bus.vidout_row   = 10'($urandom);
    bus.vidout_col   = 10'($urandom);
  endtask

  task automatic run_burst(input bit is_write, input logic [1:0] rot, input bit frame,
                           input logic [9:0] row, input logic [9:0] col, input int drop_after,
                           output int req_cyc);
    int budget;
    quiesce();
    bus.rotation = rot;
    if (is_write) begin
      bus.vidin_frame = frame;
      bus.vidin_row   = row;
      bus.vidin_col   = col;
      bus.vidin_req   = 1'b1;
    end else begin
      bus.vidout_frame = frame;
      bus.vidout_row   = row;
      bus.vidout_col   = col;
      bus.vidout_req   = 1'b1;
    end
    req_cyc = cyc;
    budget  = 0;
    while (words.size() < drop_after && budget < 300) begin
      step();
      budget++;
      bus.vidin_d = 16'($urandom);
      if (words.size() > 0) scramble_fields();
    end
    bus.vidin_req  = 1'b0;
    bus.vidout_req = 1'b0;
    chk("burst_reached_drop_point", words.size() >= drop_after, 1);
    repeat (10) step();
  endtask

  task automatic check_burst(input string tag, input bit is_write, input bit rot0, input int frame,
                             input int row, input int col, input int n_exp, input bit lat0,
                             input int req_cyc);
    chk($sformatf("%s_words", tag), words.size(), n_exp);
    chk($sformatf("%s_acks", tag), is_write ? vin_cyc.size() : vout_cyc.size(), n_exp);
    chk($sformatf("%s_other_acks", tag), is_write ? vout_cyc.size() : vin_cyc.size(), 0);
    if (lat0 && words.size() > 0) chk($sformatf("%s_grant_latency", tag), words[0].cyc, req_cyc + 1);
    for (int i = 0; i < words.size() && i < n_exp; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), words[i].addr, model_addr(is_write, rot0, frame, row, col, i));
      chk($sformatf("%s_we%0d", tag, i), words[i].we, is_write);
      chk($sformatf("%s_last%0d", tag, i), words[i].last, is_write ? (i == 15) : (i == n_exp - 1));
      if (is_write) begin
        chk($sformatf("%s_wdata%0d", tag, i), words[i].wdata, words[i].vin_d);
        if (i < vin_cyc.size()) chk($sformatf("%s_vin_ack_cyc%0d", tag, i), vin_cyc[i], words[i].cyc);
        if (i > 0 && lat0)
          chk($sformatf("%s_wr_spacing%0d", tag, i), words[i].cyc - words[i-1].cyc, 1 + WRITE_GAP);
        else if (i > 0)
          chk($sformatf("%s_wr_min_spacing%0d", tag, i), (words[i].cyc - words[i-1].cyc) >= 1 + WRITE_GAP, 1);
      end else begin
        if (i < vout_cyc.size()) begin
          chk($sformatf("%s_vout_lag%0d", tag, i), vout_cyc[i], words[i].cyc + 1);
          chk($sformatf("%s_vout_d%0d", tag, i), vout_d[i],
              rdata_of(model_addr(0, 0, frame, row, col, i)));
        end
        if (i > 0 && lat0) chk($sformatf("%s_rd_spacing%0d", tag, i), words[i].cyc - words[i-1].cyc, 1);
      end
    end
  endtask

  initial begin : main
    vec_t        vecs[6];
    int          rc;
    int          budget;
    int          b_type[$];
    int          b_len[$];
    int          b_first[$];
    int          b_end[$];
    bit          w;
    int          m;
    int          n;
    logic [1:0]  r_rot;
    bit          r_frame;
    logic [9:0]  r_row;
    logic [9:0]  r_col;

    vecs[0] = '{1'b1, 2'd1, 1'b0, 10'd5,    10'h020,  16, 21'h008005, 21'h00BC05};
    vecs[1] = '{1'b1, 2'd0, 1'b0, 10'd5,    10'h020,  16, 21'h00BC05, 21'h008005};
    vecs[2] = '{1'b0, 2'd0, 1'b1, 10'd3,    10'd1020, 8,  21'h100FFC, 21'h100C03};
    vecs[3] = '{1'b1, 2'd3, 1'b1, 10'd1023, 10'h3FF,  16, 21'h1FC3FF, 21'h1FFFFF};
    vecs[4] = '{1'b0, 2'd1, 1'b0, 10'd0,    10'd0,    8,  21'h000000, 21'h000007};
    vecs[5] = '{1'b1, 2'd2, 1'b0, 10'd0,    10'h00F,  16, 21'h003C00, 21'h000000};

    bus.rotation = 2'd0; bus.vidin_req = 1'b0; bus.vidin_frame = 1'b0; bus.vidin_row = '0;
    bus.vidin_col = '0; bus.vidin_d = '0; bus.vidout_req = 1'b0; bus.vidout_frame = 1'b0;
    bus.vidout_row = '0; bus.vidout_col = '0;
    reset = 1'b1;
    step();
    step();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_last", bus.mem_last, 0);
    chk("rst_vidin_ack", bus.vidin_ack, 0);
    chk("rst_vidout_ack", bus.vidout_ack, 0);
    chk("rst_vidout_d", bus.vidout_d, 0);
    reset = 1'b0;
    step();
    chk("idle_mem_req", bus.mem_req, 0);

    lat_max = 0; lat_fixed = 1'b0;
    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].is_write, vecs[v].rot, vecs[v].frame, vecs[v].row, vecs[v].col,
                vecs[v].n_words, rc);
      if (words.size() > 0) begin
        chk($sformatf("vec%0d_first_addr", v), words[0].addr, vecs[v].first_addr);
        chk($sformatf("vec%0d_last_addr", v), words[words.size()-1].addr, vecs[v].last_addr);
      end
      check_burst($sformatf("vec%0d", v), vecs[v].is_write, vecs[v].rot[0], vecs[v].frame,
                  vecs[v].row, vecs[v].col, vecs[v].n_words, 1'b1, rc);
    end

    lat_max = 0; lat_fixed = 1'b0;
    quiesce();
    bus.vidin_frame = 1'b0; bus.vidin_row = 10'd40; bus.vidin_col = 10'h100; bus.rotation = 2'd1;
    bus.vidout_frame = 1'b1; bus.vidout_row = 10'd60; bus.vidout_col = 10'd200;
    bus.vidin_req = 1'b1; bus.vidout_req = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_log();
    budget = 0;
    while (words.size() < 48 && budget < 400) begin
      step();
      budget++;
    end
    bus.vidin_req = 1'b0; bus.vidout_req = 1'b0;
    chk("alt_done", words.size() >= 48, 1);
    repeat (10) step();
    for (int i = 0; i < words.size(); i++) begin
      if (i == 0 || words[i-1].last) begin
        b_type.push_back(int'(words[i].we));
        b_len.push_back(1);
        b_first.push_back(words[i].cyc);
        b_end.push_back(words[i].cyc);
      end else begin
        b_len[b_len.size()-1]++;
        b_end[b_end.size()-1] = words[i].cyc;
      end
    end
    chk("alt_bursts", b_type.size(), 4);
    for (int j = 0; j < b_type.size() && j < 4; j++) begin
      chk($sformatf("alt_type%0d", j), b_type[j], (j % 2 == 0) ? 1 : 0);
      chk($sformatf("alt_len%0d", j), b_len[j], (j % 2 == 0) ? 16 : READ_BURST);
      if (j > 0) chk($sformatf("alt_turnaround%0d", j), (b_first[j] - b_end[j-1]) >= 2, 1);
    end

    quiesce();
    bus.vidout_frame = 1'b0; bus.vidout_row = 10'd77; bus.vidout_col = 10'd500;
    bus.vidout_req = 1'b1;
    rc = cyc;
    step();
    step();
    step();
    bus.vidout_req = 1'b0;
    repeat (8) step();
    check_burst("drop3", 1'b0, 1'b0, 0, 77, 500, 3, 1'b1, rc);
    reset = 1'b1;
    step();
    chk("rst_clears_vidout_d", bus.vidout_d, 0);
    chk("rst_clears_vidout_ack", bus.vidout_ack, 0);
    reset = 1'b0;

    lat_max = 3; lat_fixed = 1'b1;
    quiesce();
    bus.rotation = 2'd1; bus.vidin_frame = 1'b0; bus.vidin_row = 10'd9; bus.vidin_col = 10'h150;
    bus.vidin_req = 1'b1;
    budget = 0;
    while (!(words.size() == 6 && bus.mem_req) && budget < 300) begin
      step();
      budget++;
    end
    chk("rstmid_reached_word7", words.size() == 6 && bus.mem_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_mem_req", bus.mem_req, 0);
    chk("rstmid_vidin_ack", bus.vidin_ack, 0);
    chk("rstmid_vidout_ack", bus.vidout_ack, 0);
    chk("rstmid_words", words.size(), 6);
    budget = 0;
    while (words.size() < 7 && budget < 50) begin
      step();
      budget++;
    end
    chk("rstmid_restart_seen", words.size(), 7);
    if (words.size() >= 7) chk("rstmid_restart_addr", words[6].addr, model_addr(1, 1, 0, 9, 'h150, 0));
    chk("rstmid_ack_count", vin_cyc.size(), words.size());
    bus.vidin_req = 1'b0;

    for (int t = 0; t < 30; t++) begin
      lat_max   = int'($urandom_range(3, 0));
      lat_fixed = 1'b0;
      w       = 1'($urandom);
      r_rot   = 2'($urandom);
      r_frame = 1'($urandom);
      r_row   = 10'($urandom);
      r_col   = 10'($urandom);
      if (w) begin
        m = int'($urandom_range(16, 1));
        n = m;
      end else begin
        m = int'($urandom_range(READ_BURST, 1));
        n = (m < READ_BURST) ? m + 1 : READ_BURST;
      end
      run_burst(w, r_rot, r_frame, r_row, r_col, m, rc);
      check_burst($sformatf("rnd%0d", t), w, r_rot[0], r_frame, r_row, r_col, n, lat_max == 0, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotate_sdram_sched.md
# rotate_sdram_sched

Schedules the shared SDRAM word port between the rotating scandoubler's write stream (vidin, 16-word row bursts) and read stream (vidout, 8-word bursts). It forms cornerturned word addresses and paces write data to match the source's registered linebuffer. It arbitrates fairly between the two streams and converts both into one word-handshake memory port. It sits between scandoubler_rotate and the SDRAM controller's video port.

## Interface
- ADDR_WIDTH, 21: memory word address width; layout {frame, major[9:0], minor[9:0]}.
- WRITE_GAP, 2: idle cycles forced on mem_req after each accepted write word.
- READ_BURST, 8: maximum words per read grant.
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- rotation  in  2  bit0=1: write burst ascends from col[3:0]=0; bit0=0: descends from 15.
- vidin_req  in  1  write stream request.
- vidin_frame  in  1  write frame select.
- vidin_row  in  10  source row.
- vidin_col  in  10  source column; bits [9:4] valid at grant.
- vidin_d  in  16  RGB565 write data.
- vidin_ack  out  1  one-cycle pulse per write word accepted.
- vidout_req  in  1  read stream request.
- vidout_frame  in  1  read frame select.
- vidout_row  in  10  output row (input column).
- vidout_col  in  10  output x (input row); valid at grant.
- vidout_d  out  16  read data, valid with vidout_ack.
- vidout_ack  out  1  one-cycle pulse per read word.
- mem_req  out  1  word request.
- mem_we  out  1  1 = write.
- mem_last  out  1  final word of current burst.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid with mem_ack on reads.
- mem_ack  in  1  word completed; only asserted while mem_req=1.

## Operation
- States:
  - IDLE, WRITE, WGAP, READ.
  - Reset forces IDLE and last_served=READ.
  - Reset forces mem_req, mem_we, mem_last, vidin_ack and vidout_ack to 0.
  - Reset forces the word counter k to 0 and vidout_d to 0.
- IDLE grant: on a registered decision, one request wins.
  - Only one request: that one wins.
  - Both requests: the stream opposite to last_served wins.
  - On grant, last_served is updated.
- Write grant:
  - Latch frame, row and col[9:4].
  - Set k=0 and dir=rotation[0].
  - Enter WRITE.
- Write addressing:
  - Address = {frame, col_hi, lo, row}, where lo = dir ? k[3:0] : 15-k[3:0].
  - Write addresses are cornerturned: input column is the major index.
- mem_wdata = vidin_d, passed through combinationally.
- In WRITE, on mem_ack:
  - Pulse vidin_ack and increment k.
  - If k==15, return to IDLE.
  - Otherwise enter WGAP, with mem_req=0 for WRITE_GAP cycles.
- Leaving WGAP:
  - If vidin_req=0, return to IDLE (early-terminated burst).
  - Otherwise return to WRITE.
- Read grant:
  - Latch frame, row and col.
  - Set k=0 and enter READ.
- Read addressing:
  - Address = {frame, vidout_row, vidout_col_latched + k}; 10-bit add that wraps mod 1024.
  - Read words are back-to-back with no gap.
- In READ, on mem_ack:
  - Pulse vidout_ack and register vidout_d=mem_rdata.
  - Increment k.
  - If k==READ_BURST-1, or vidout_req=0 sampled that cycle, return to IDLE.
- mem_last=1 when:
  - WRITE and k==15; or
  - READ and (k==READ_BURST-1 or vidout_req=0).
- The controller ends its burst after acking a word with mem_last=1.
- Requests dropping mid-burst:
  - A request dropping while its burst is active is honoured only at word boundaries (as above).
  - A request dropping in IDLE before grant: no grant.
- Reset asserted mid-burst: immediate IDLE, with no further ack pulses.

## Timing
- Grant latency: request sampled high in IDLE, then mem_req=1 on the next cycle.
- Write data latency: vidin_ack pulses in the same cycle as mem_ack (combinational). The write word period is at minimum 1+WRITE_GAP cycles (3 by default).
- Read data latency: vidout_ack and vidout_d are registered, one cycle after mem_ack.
- Burst turnaround: at least one IDLE cycle between any two bursts.
- mem_addr, mem_we and mem_last are stable while mem_req=1 until mem_ack. They change only the cycle after mem_ack.

## Test plan
- Write-only, rotation=1, row=5, col=0x20, frame=0, controller acks immediately:
  - 16 vidin_ack pulses, spaced 3 cycles apart.
  - Addresses {0,2,0..15,5}.
  - mem_last on the 16th word, then IDLE.
- Write-only, rotation=0: lo sequence is 15 down to 0; other fields as above.
- Read-only, row=3, col=1020, frame=1:
  - 8 back-to-back words at minor 1020,1021,1022,1023,0,1,2,3.
  - vidout_ack lags each mem_ack by 1 cycle.
- Both requests held continuously from reset:
  - Grants go write, read, write, read.
  - No stream waits more than one opposing burst.
- Read with vidout_req dropped after the 3rd ack:
  - mem_last asserted on the 3rd word, exactly 3 vidout_ack pulses, then IDLE.
- Reset pulsed during the 7th write word:
  - The next cycle shows mem_req=0 and no acks.
  - A subsequent grant restarts at k=0.
